// File: rtl/tm_input_conditioner_if.sv
// Bundle of raw operator inputs and conditioned strobes between the front
// panel (master) and tm_input_conditioner (slave).
interface tm_input_conditioner_if #(
  parameter int DATA_W = 6
);
  logic              next_btn;
  logic              done_btn;
  logic [DATA_W-1:0] input_data;
  logic              next_pulse;
  logic              done_pulse;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        entry_idx;

  modport master (
    output next_btn, done_btn, input_data,
    input  next_pulse, done_pulse, data_out, entry_idx
  );

  modport slave (
    input  next_btn, done_btn, input_data,
    output next_pulse, done_pulse, data_out, entry_idx
  );
endinterface

// File: rtl/tm_input_conditioner.sv
// Synchronizes and debounces the Next/Done buttons and the switch bank, emitting
// one-cycle strobes with atomically captured data. Optional auto-repeat on Next: TM_AUTO_REPEAT_EN.
module tm_input_conditioner #(
  parameter int DATA_W          = 6,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int REPEAT_CYCLES   = 8
) (
  input logic                     clock,
  input logic                     reset,
  tm_input_conditioner_if.slave   bus
);

  typedef struct packed {
    logic        s1;
    logic        s2;
    logic        db;
    logic [15:0] cnt;
  } btn_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer followed by the debounce step for one button.
  function automatic btn_t btn_step(input btn_t cur, input logic raw);
    btn_t nxt;
    nxt    = cur;
    nxt.s1 = raw;
    nxt.s2 = cur.s1;
    if (cur.s2 == cur.db) begin
      nxt.cnt = '0;
    end else if (cur.cnt == CNT_LAST) begin
      nxt.db  = cur.s2;
      nxt.cnt = '0;
    end else begin
      nxt.cnt = cur.cnt + 16'd1;
    end
    return nxt;
  endfunction

  btn_t              next_q, next_d;
  btn_t              done_q, done_d;
  logic [DATA_W-1:0] data_s1_q, data_s1_d;
  logic [DATA_W-1:0] data_s2_q, data_s2_d;
  logic              next_pulse_q, next_pulse_d;
  logic              done_pulse_q, done_pulse_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [7:0]        entry_idx_q, entry_idx_d;
  logic              next_fire;
  logic              done_fire;

`ifdef TM_AUTO_REPEAT_EN
  localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rpt_q, rpt_d;
  logic        rpt_hit;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_d    = btn_step(next_q, bus.next_btn);
    done_d    = btn_step(done_q, bus.done_btn);
    data_s1_d = bus.input_data;
    data_s2_d = data_s1_q;

    done_fire = ~done_q.db & done_d.db;
`ifdef TM_AUTO_REPEAT_EN
    // Repeat only while the press is still held, counting from the last strobe.
    rpt_hit   = next_q.db & next_d.db & (rpt_q == RPT_LAST);
    next_fire = (~next_q.db & next_d.db) | rpt_hit;
    if (next_fire || !next_q.db) rpt_d = '0;
    else                         rpt_d = rpt_q + 16'd1;
`else
    next_fire = ~next_q.db & next_d.db;
`endif

    // Done wins a same-edge collision; the Next press is dropped.
    next_pulse_d = next_fire & ~done_fire;
    done_pulse_d = done_fire;
    data_out_d   = (next_fire || done_fire) ? data_s2_q : data_out_q;

    entry_idx_d = entry_idx_q;
    if (done_fire)      entry_idx_d = '0;
    else if (next_fire) entry_idx_d = entry_idx_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      next_q       <= '0;
      done_q       <= '0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      next_pulse_q <= 1'b0;
      done_pulse_q <= 1'b0;
      data_out_q   <= '0;
      entry_idx_q  <= '0;
`ifdef TM_AUTO_REPEAT_EN
      rpt_q        <= '0;
`endif
    end else begin
      next_q       <= next_d;
      done_q       <= done_d;
      data_s1_q    <= data_s1_d;
      data_s2_q    <= data_s2_d;
      next_pulse_q <= next_pulse_d;
      done_pulse_q <= done_pulse_d;
      data_out_q   <= data_out_d;
      entry_idx_q  <= entry_idx_d;
`ifdef TM_AUTO_REPEAT_EN
      rpt_q        <= rpt_d;
`endif
    end
  end

  assign bus.next_pulse = next_pulse_q;
  assign bus.done_pulse = done_pulse_q;
  assign bus.data_out   = data_out_q;
  assign bus.entry_idx  = entry_idx_q;

endmodule

// File: tb/tb_tm_input_conditioner.sv
// Directed bench for tm_input_conditioner: expected strobes (kind, cycle, data,
// index) are queued as buttons are driven and checked as the DUT emits them.
module tb_tm_input_conditioner;

  localparam int DATA_W = 6;
  localparam int D      = 2;
  localparam int RPT    = 8;

  typedef struct {
    logic [1:0] kind;   // {next, done}
    logic [5:0] data;
    logic [7:0] idx;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] model_idx = '0;
  exp_t sb[$];

  tm_input_conditioner_if #(.DATA_W(DATA_W)) bif ();

  tm_input_conditioner #(
    .DATA_W(DATA_W), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(RPT)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one press; queue the expected strobe plus any auto-repeat strobes.
  task automatic press(input logic nxt, input logic dn, input logic [5:0] d,
                       input int hold, input int gap, input int reps);
    exp_t e;
    bif.input_data = d;
    bif.next_btn   = nxt;
    bif.done_btn   = dn;
    for (int k = 0; k <= reps; k++) begin
      if (dn) model_idx = '0;
      else    model_idx = model_idx + 8'd1;
      e.kind = dn ? 2'b01 : 2'b10;
      e.data = d;
      e.idx  = model_idx;
      e.cyc  = cyc + 2 + D + k * RPT;
      sb.push_back(e);
    end
    tick(hold);
    bif.next_btn = 1'b0;
    bif.done_btn = 1'b0;
    tick(gap);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bif.next_pulse || bif.done_pulse)) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {30'd0, bif.next_pulse, bif.done_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {30'd0, bif.next_pulse, bif.done_pulse}, {30'd0, e.kind});
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_data", {26'd0, bif.data_out}, {26'd0, e.data});
        check("pulse_idx", {24'd0, bif.entry_idx}, {24'd0, e.idx});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int n_reps;
`ifdef TM_AUTO_REPEAT_EN
    n_reps = 3;
`else
    n_reps = 0;
`endif
    reset          = 1'b1;
    bif.next_btn   = 1'b0;
    bif.done_btn   = 1'b0;
    bif.input_data = '0;
    tick(3);
    check("reset_outputs", {16'd0, bif.next_pulse, bif.done_pulse, bif.data_out, bif.entry_idx},
          32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_outputs", {16'd0, bif.next_pulse, bif.done_pulse, bif.data_out, bif.entry_idx},
            32'd0);
    end

    // Single press held 6 cycles: one strobe, nothing more while held.
    press(1'b1, 1'b0, 6'd2, 6, 6, 0);

    // One-cycle glitch with different data must be rejected.
    bif.input_data = 6'd5;
    bif.next_btn   = 1'b1;
    tick(1);
    bif.next_btn   = 1'b0;
    tick(6);
    check("glitch_idx", {24'd0, bif.entry_idx}, 32'd1);
    check("glitch_data", {26'd0, bif.data_out}, 32'd2);

    // Done clears the index, then three entries and a closing Done.
    press(1'b0, 1'b1, 6'd5, 3, 4, 0);
    press(1'b1, 1'b0, 6'd1, 3, 4, 0);
    press(1'b1, 1'b0, 6'd0, 3, 4, 0);
    press(1'b1, 1'b0, 6'd2, 3, 4, 0);
    press(1'b0, 1'b1, 6'd3, 3, 6, 0);

    // Simultaneous rise: Done only.
    press(1'b1, 1'b0, 6'd9, 3, 6, 0);
    press(1'b1, 1'b1, 6'd12, 3, 6, 0);
    check("simul_idx", {24'd0, bif.entry_idx}, 32'd0);

    // Reset mid-debounce with the button held across deassertion.
    bif.input_data = 6'd7;
    bif.next_btn   = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midreset_outputs", {16'd0, bif.next_pulse, bif.done_pulse, bif.data_out, bif.entry_idx},
          32'd0);
    reset     = 1'b0;
    model_idx = '0;
    press(1'b1, 1'b0, 6'd7, 5, 6, 0);

    // Long hold: auto-repeat when enabled, otherwise one strobe.
    press(1'b1, 1'b0, 6'd33, 30, 10, n_reps);

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      tick(1);
      w++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_idx", {24'd0, bif.entry_idx}, {24'd0, model_idx});
    check("final_data", {26'd0, bif.data_out}, 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm_input_conditioner.md
Name: tm_input_conditioner

Overview:
- Front-end conditioner that sits directly upstream of the TuringMachine core.
- Takes raw, asynchronous push-button levels (Next, Done) and the 6-bit switch bank, and synchronizes and debounces them.
- Emits clean one-cycle next_pulse / done_pulse strobes plus a data word captured atomically with each strobe.
- Also maintains an entry index counting accepted Next presses since the last Done, for use in programming and tape loading.

Parameters:
- DATA_W, 6, width of input_data / data_out.
- DEBOUNCE_CYCLES, 2, number of consecutive cycles a synchronized button must differ from its debounced level before it flips. Legal range 1..65535; counter is 16 bits.
- REPEAT_CYCLES, 8, auto-repeat period in cycles. Used only with TM_AUTO_REPEAT_EN.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- next_btn  in  1  raw Next button level, asynchronous.
- done_btn  in  1  raw Done button level, asynchronous.
- input_data  in  DATA_W  raw switch bank, asynchronous.
- next_pulse  out  1  one-cycle strobe per accepted Next press.
- done_pulse  out  1  one-cycle strobe per accepted Done press.
- data_out  out  DATA_W  switch value captured with the most recent strobe.
- entry_idx  out  8  count of next_pulses since reset or the last done_pulse.

Behaviour:
- Reset (reset high at an edge):
  - sync flops, debounced levels, debounce counters, next_pulse, done_pulse, data_out and entry_idx all go to 0.
  - Outputs read 0 in the cycle after the reset edge.
- Synchronizer:
  - next_btn, done_btn and every bit of input_data pass through two flops (s1, s2).
  - Only s2 values are used downstream.
- Debounce, per button, independently:
  - State is level db and counter cnt.
  - At each edge where s2 == db: cnt <= 0.
  - At each edge where s2 != db:
    - if cnt == DEBOUNCE_CYCLES-1, then db <= s2 and cnt <= 0;
    - otherwise cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 is rejected.
- Pulse generation:
  - Registered; asserted for exactly one cycle after the edge at which db flips 0->1.
  - No pulse is generated on a 1->0 flip.
- Latency:
  - Button sampled high at edge E0 and held.
  - Pulse is visible in the cycle after edge E(1+DEBOUNCE_CYCLES).
  - With the default DEBOUNCE_CYCLES=2, that is 3 edges.
- Data capture:
  - At the edge a pulse is registered, data_out <= s2 of input_data.
  - data_out then holds until the next pulse edge.
- entry_idx:
  - Increments by 1 at each next_pulse edge, wrapping 255->0.
  - Cleared to 0 at a done_pulse edge.
- Simultaneous flips (Next and Done db both flip 0->1 on the same edge):
  - done_pulse=1, next_pulse=0 (the Next press is discarded).
  - entry_idx <= 0; data_out captured once.
- Button held through reset deassertion: db restarts at 0, so it produces one pulse after the normal latency.
- Reset mid-debounce: cnt is cleared and no pulse is produced from the interrupted count.
- Release handling: a held button produces no further pulses; a new press needs db to return to 0 first.

Optional Feature:
- Macro TM_AUTO_REPEAT_EN.
- When defined:
  - While Next db stays 1, a 16-bit repeat counter runs, reset by each next_pulse.
  - Every REPEAT_CYCLES cycles after the previous next_pulse, it emits another next_pulse with data capture and entry_idx increment.
  - Releasing the button stops repetition.
  - Done has no auto-repeat.
  - The Done-priority rule applies to repeat pulses too.
- When undefined: exactly one next_pulse per press, the repeat counter is absent, and REPEAT_CYCLES is ignored.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, no pulses.
- input_data=2, next_btn high from E0 for 6 cycles (D=2) -> single next_pulse in cycle after E3; data_out=2; entry_idx=1; no further pulses while held.
- next_btn high for 1 cycle only (glitch) -> no next_pulse; entry_idx and data_out unchanged.
- Three presses with data 1, 0, 2, each held 3 cycles with gaps of 4 low cycles, then done_btn press -> three next_pulses with data_out 1, 0, 2; entry_idx 1, 2, 3; done_pulse then entry_idx=0.
- next_btn and done_btn rising on the same cycle -> done_pulse only; next_pulse stays 0; entry_idx=0.
- With TM_AUTO_REPEAT_EN and REPEAT_CYCLES=8, next_btn held 30 cycles -> first pulse at latency 3, then repeats every 8 cycles (4 pulses total); entry_idx=4. With the macro undefined -> 1 pulse.
